// File: rtl/j1_boot_pkg.sv
// Shared definitions for the j1 boot loader: FSM states and frame layout.
// Host-side tools and the bench frame builder use the same constants.
package j1_boot_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_SYNC = 3'd0,
    ST_LEN_LO    = 3'd1,
    ST_LEN_HI    = 3'd2,
    ST_DATA_LO   = 3'd3,
    ST_DATA_HI   = 3'd4,
    ST_CHK       = 3'd5,
    ST_RUN       = 3'd6
  } boot_state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // Byte offsets of frame fields; data words start at FLD_DATA, CHK follows the last word.
  localparam int FLD_SYNC     = 0;
  localparam int FLD_LEN_LO   = 1;
  localparam int FLD_LEN_HI   = 2;
  localparam int FLD_DATA     = 3;
  localparam int FRAME_EXTRA  = 4;

endpackage

// File: rtl/j1_boot_timer.sv
// Loadable down-counter used for both the boot and inter-byte timeouts.
// Holds at zero; expired stays high until the next load.
module j1_boot_timer #(
  parameter int TO_W = 24
) (
  input  logic            clk,
  input  logic            resetq,
  input  logic            load,
  input  logic [TO_W-1:0] value,
  output logic            expired
);

  logic [TO_W-1:0] count_reg;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq)
      count_reg <= '0;
    else if (load)
      count_reg <= value;
    else if (count_reg != '0)
      count_reg <= count_reg - 1'b1;
  end

  assign expired = (count_reg == '0);

endmodule

// File: rtl/j1_boot_loader.sv
// Boot sequencer for the j1 core: receives a framed image over the RX byte stream,
// writes it to code RAM, verifies the checksum and then releases the core reset.
module j1_boot_loader
  import j1_boot_pkg::*;
#(
  parameter int          ADDR_W    = 13,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int          TO_W      = 24,
  parameter int unsigned BOOT_TO   = 12000000,
  parameter int unsigned BYTE_TO   = 250000
) (
  input  logic              clk,
  input  logic              resetq,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              reload,
  output logic              core_resetq,
  output logic              cram_we,
  output logic [ADDR_W-1:0] cram_addr,
  output logic [15:0]       cram_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [31:0] MAX_LEN = 32'd1 << ADDR_W;

  boot_state_t state_reg, state_next;

  logic              entry_reg;
  logic [7:0]        sum_reg;
  logic [7:0]        len_lo_reg;
  logic [ADDR_W:0]   len_reg;
  logic [ADDR_W:0]   idx_reg;
  logic [7:0]        data_lo_reg;
  logic              cram_we_reg;
  logic [ADDR_W-1:0] cram_addr_reg;
  logic [15:0]       cram_wdata_reg;
  logic              done_reg;
  logic              err_reg;
  logic              core_resetq_reg;
  logic              rx_ready_reg;

  logic              accept;
  logic [15:0]       len_word;
  logic              len_bad;
  logic [ADDR_W:0]   idx_inc;
  logic              last_word;
  logic [7:0]        sum_plus;
  logic              tmr_load;
  logic [TO_W-1:0]   tmr_value;
  logic              tmr_expired;
  logic              timeout;
  logic              frame_err;

  assign accept    = rx_valid & rx_ready_reg;
  assign len_word  = {rx_data, len_lo_reg};
  assign len_bad   = (len_word == 16'd0) || ({16'd0, len_word} > MAX_LEN);
  assign idx_inc   = idx_reg + {{ADDR_W{1'b0}}, 1'b1};
  assign last_word = (idx_inc == len_reg);
  assign sum_plus  = sum_reg + rx_data;

  // The first cycle of each state reloads the timer, so a stale zero never counts as expiry.
  assign tmr_load  = accept | entry_reg;
  assign tmr_value = (state_reg == ST_WAIT_SYNC) ? TO_W'(BOOT_TO) : TO_W'(BYTE_TO);
  assign timeout   = tmr_expired & ~entry_reg & ~accept;

  j1_boot_timer #(
    .TO_W(TO_W)
  ) u_timer (
    .clk    (clk),
    .resetq (resetq),
    .load   (tmr_load),
    .value  (tmr_value),
    .expired(tmr_expired)
  );

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq)
      state_reg <= ST_WAIT_SYNC;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    frame_err  = 1'b0;
    if (reload) begin
      state_next = ST_WAIT_SYNC;
    end else begin
      case (state_reg)
        ST_WAIT_SYNC: begin
          if (accept) begin
            if (rx_data == SYNC_BYTE)
              state_next = ST_LEN_LO;
          end else if (timeout) begin
            state_next = ST_RUN;
          end
        end
        ST_LEN_LO: begin
          if (accept)       state_next = ST_LEN_HI;
          else if (timeout) frame_err  = 1'b1;
        end
        ST_LEN_HI: begin
          if (accept) begin
            if (len_bad) frame_err  = 1'b1;
            else         state_next = ST_DATA_LO;
          end else if (timeout) begin
            frame_err = 1'b1;
          end
        end
        ST_DATA_LO: begin
          if (accept)       state_next = ST_DATA_HI;
          else if (timeout) frame_err  = 1'b1;
        end
        ST_DATA_HI: begin
          if (accept)       state_next = last_word ? ST_CHK : ST_DATA_LO;
          else if (timeout) frame_err  = 1'b1;
        end
        ST_CHK: begin
          if (accept) begin
            if (sum_plus == 8'd0) state_next = ST_RUN;
            else                  frame_err  = 1'b1;
          end else if (timeout) begin
            frame_err = 1'b1;
          end
        end
        ST_RUN:  state_next = ST_RUN;
        default: state_next = ST_WAIT_SYNC;
      endcase
      if (frame_err)
        state_next = ST_WAIT_SYNC;
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      entry_reg       <= 1'b1;
      sum_reg         <= '0;
      len_lo_reg      <= '0;
      len_reg         <= '0;
      idx_reg         <= '0;
      data_lo_reg     <= '0;
      cram_we_reg     <= 1'b0;
      cram_addr_reg   <= '0;
      cram_wdata_reg  <= '0;
      done_reg        <= 1'b0;
      err_reg         <= 1'b0;
      core_resetq_reg <= 1'b0;
      rx_ready_reg    <= 1'b0;
    end else begin
      cram_we_reg     <= 1'b0;
      entry_reg       <= reload || (state_next != state_reg);
      rx_ready_reg    <= (state_next != ST_RUN);
      core_resetq_reg <= (state_reg == ST_RUN) && (state_next == ST_RUN);
      if (reload) begin
        done_reg <= 1'b0;
      end else begin
        if (frame_err) begin
          err_reg  <= 1'b1;
          done_reg <= 1'b0;
        end
        if (accept) begin
          sum_reg <= sum_plus;
          case (state_reg)
            ST_WAIT_SYNC: begin
              if (rx_data == SYNC_BYTE) begin
                sum_reg  <= '0;
                err_reg  <= 1'b0;
                done_reg <= 1'b0;
              end
            end
            ST_LEN_LO: len_lo_reg <= rx_data;
            ST_LEN_HI: begin
              len_reg <= len_word[ADDR_W:0];
              idx_reg <= '0;
            end
            ST_DATA_LO: data_lo_reg <= rx_data;
            ST_DATA_HI: begin
              cram_we_reg    <= 1'b1;
              cram_addr_reg  <= idx_reg[ADDR_W-1:0];
              cram_wdata_reg <= {rx_data, data_lo_reg};
              idx_reg        <= idx_inc;
            end
            ST_CHK: begin
              if (sum_plus == 8'd0)
                done_reg <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    busy = (state_reg != ST_RUN);
  end

  assign rx_ready    = rx_ready_reg;
  assign core_resetq = core_resetq_reg;
  assign cram_we     = cram_we_reg;
  assign cram_addr   = cram_addr_reg;
  assign cram_wdata  = cram_wdata_reg;
  assign done        = done_reg;
  assign err         = err_reg;

endmodule
